// File: rtl/wb_commit_queue.sv
// -----------------------------------------------------------------------------
// wb_commit_queue
//   Write-back commit queue sitting between two result producers and a
//   dual-write-port register file. Up to two results are accepted per cycle
//   (older slot 1 first, then younger slot 2). Up to two entries are drained
//   per cycle straight from the head. The register file writes on the falling
//   edge, so the drain outputs are combinational from the queue state.
//
//   Optional feature macro: WB_FORWARD_EN
//     defined   -> fwd_hit/fwd_data report the youngest queued entry whose
//                  destination matches fwd_addr (nonzero), combinationally.
//     undefined -> fwd_hit and fwd_data are tied to 0 and no comparators exist.
//
// Parameters
//   DEPTH     queue entries, power of two, >= 4
//
// Ports
//   CLK                    clock, all state changes on the rising edge
//   RSTn                   asynchronous active-low reset
//   in_valid1/2            result valid, slot 1 older, slot 2 younger
//   in_addr1/2   [4:0]     destination register (r0 results are dropped)
//   in_data1/2   [31:0]    result value
//   in_ready               at least two free entries (pre-edge)
//   drain_en               register-file write ports available this cycle
//   WE1/WE2                write enables to the register file
//   Aw1/Aw2      [4:0]     write addresses (0 while the matching WE is 0)
//   WD1/WD2      [31:0]    write data (0 while the matching WE is 0)
//   fwd_addr     [4:0]     forwarding lookup address
//   fwd_hit                a queued entry matches fwd_addr
//   fwd_data     [31:0]    data of the youngest matching queued entry
// -----------------------------------------------------------------------------
module wb_commit_queue #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        in_valid1,
  input  logic        in_valid2,
  input  logic [4:0]  in_addr1,
  input  logic [4:0]  in_addr2,
  input  logic [31:0] in_data1,
  input  logic [31:0] in_data2,
  output logic        in_ready,
  input  logic        drain_en,
  output logic        WE1,
  output logic        WE2,
  output logic [4:0]  Aw1,
  output logic [4:0]  Aw2,
  output logic [31:0] WD1,
  output logic [31:0] WD2,
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry storage: no reset, validity is implied by head/count.
  logic [4:0]    r_addr_mem [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_ready;
  logic          w_acc1;
  logic          w_acc2;
  logic [1:0]    w_push_n;
  logic [AW-1:0] w_tail2;
  logic [AW-1:0] w_head1;
  logic          w_pres1;
  logic          w_pres2;
  logic          w_same;
  logic [1:0]    w_pop_n;
  logic          w_we1;
  logic          w_we2;

  // Free entries >= 2 on the pre-edge count. Because acceptance requires
  // this, a push can never overflow even when nothing is popped.
  assign w_ready  = (r_count <= (DEPTH_C - CW'(2)));
  assign in_ready = w_ready;

  // Results to r0 are discarded before they reach the queue.
  assign w_acc1   = w_ready & in_valid1 & (in_addr1 != 5'd0);
  assign w_acc2   = w_ready & in_valid2 & (in_addr2 != 5'd0);
  assign w_push_n = {1'b0, w_acc1} + {1'b0, w_acc2};
  // Slot 2 lands right behind slot 1, or at the tail if slot 1 was dropped.
  assign w_tail2  = w_acc1 ? (r_tail + AW'(1)) : r_tail;

  // Drain presentation straight from the head.
  assign w_head1  = r_head + AW'(1);
  assign w_pres1  = drain_en & (r_count >= CW'(1));
  assign w_pres2  = drain_en & (r_count >= CW'(2));
  // Two writes to one register in the same cycle: only the younger survives,
  // but both entries still leave the queue.
  assign w_same   = w_pres2 & (r_addr_mem[r_head] == r_addr_mem[w_head1]);
  assign w_pop_n  = {1'b0, w_pres1} + {1'b0, w_pres2};

  assign w_we1    = w_pres1 & ~w_same;
  assign w_we2    = w_pres2;

  assign WE1 = w_we1;
  assign WE2 = w_we2;
  assign Aw1 = w_we1 ? r_addr_mem[r_head]  : 5'd0;
  assign WD1 = w_we1 ? r_data_mem[r_head]  : 32'd0;
  assign Aw2 = w_we2 ? r_addr_mem[w_head1] : 5'd0;
  assign WD2 = w_we2 ? r_data_mem[w_head1] : 32'd0;

  // Storage writes (no reset needed).
  always_ff @(posedge CLK) begin
    if (w_acc1) begin
      r_addr_mem[r_tail] <= in_addr1;
      r_data_mem[r_tail] <= in_data1;
    end
    if (w_acc2) begin
      r_addr_mem[w_tail2] <= in_addr2;
      r_data_mem[w_tail2] <= in_data2;
    end
  end

  // Pointers and occupancy. Pointer arithmetic wraps naturally at DEPTH.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop_n);
      r_tail  <= r_tail + AW'(w_push_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

`ifdef WB_FORWARD_EN
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;
  logic [AW-1:0] w_fwd_idx;

  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = 32'd0;
    w_fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_head + AW'(i);
      if ((CW'(i) < r_count) && (fwd_addr != 5'd0) &&
          (r_addr_mem[w_fwd_idx] == fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data_mem[w_fwd_idx];
      end
    end
  end

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_addr;
  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'd0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_commit_queue
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based model of the commit queue's rules.
// -----------------------------------------------------------------------------
module tb_wb_commit_queue;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic [4:0]  in_addr1 = '0, in_addr2 = '0;
  logic [31:0] in_data1 = '0, in_data2 = '0;
  logic        in_ready;
  logic        drain_en = 1'b0;
  logic        WE1, WE2;
  logic [4:0]  Aw1, Aw2;
  logic [31:0] WD1, WD2;
  logic [4:0]  fwd_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  wb_commit_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_addr1(in_addr1), .in_addr2(in_addr2),
    .in_data1(in_data1), .in_data2(in_data2),
    .in_ready(in_ready), .drain_en(drain_en),
    .WE1(WE1), .WE2(WE2), .Aw1(Aw1), .Aw2(Aw2), .WD1(WD1), .WD2(WD2),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: program-order list of queued (addr, data) results.
  logic [4:0]  q_a[$];
  logic [31:0] q_d[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic v2, input logic [4:0] a2, input logic [31:0] d2,
                        input logic de, input logic [4:0] fa);
    in_valid1 = v1; in_addr1 = a1; in_data1 = d1;
    in_valid2 = v2; in_addr2 = a2; in_data2 = d2;
    drain_en = de; fwd_addr = fa;
  endtask

  // Compare every output to the model, then apply this cycle's pops and pushes.
  task automatic model_cycle(input string tag);
    int          sz;
    logic        e_rdy, p1, p2, same, e_we1, e_we2, e_hit;
    logic [4:0]  e_aw1, e_aw2;
    logic [31:0] e_wd1, e_wd2, e_fd;
    sz    = q_a.size();
    e_rdy = (DEPTH - sz) >= 2;
    p1    = drain_en && (sz >= 1);
    p2    = drain_en && (sz >= 2);
    same  = p2 && (q_a[0] == q_a[1]);
    e_we1 = p1 && !same;
    e_we2 = p2;
    e_aw1 = e_we1 ? q_a[0] : 5'd0;
    e_wd1 = e_we1 ? q_d[0] : 32'd0;
    e_aw2 = e_we2 ? q_a[1] : 5'd0;
    e_wd2 = e_we2 ? q_d[1] : 32'd0;
    e_hit = 1'b0;
    e_fd  = 32'd0;
`ifdef WB_FORWARD_EN
    for (int i = 0; i < sz; i++) begin
      if (fwd_addr != 5'd0 && q_a[i] == fwd_addr) begin
        e_hit = 1'b1;
        e_fd  = q_d[i];
      end
    end
`endif
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
    chk({tag, ".WE1"}, 32'(WE1), 32'(e_we1));
    chk({tag, ".Aw1"}, 32'(Aw1), 32'(e_aw1));
    chk({tag, ".WD1"}, WD1, e_wd1);
    chk({tag, ".WE2"}, 32'(WE2), 32'(e_we2));
    chk({tag, ".Aw2"}, 32'(Aw2), 32'(e_aw2));
    chk({tag, ".WD2"}, WD2, e_wd2);
    chk({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(e_hit));
    chk({tag, ".fwd_data"}, fwd_data, e_fd);
    if (p1) begin void'(q_a.pop_front()); void'(q_d.pop_front()); end
    if (p2) begin void'(q_a.pop_front()); void'(q_d.pop_front()); end
    if (e_rdy) begin
      if (in_valid1 && in_addr1 != 5'd0) begin q_a.push_back(in_addr1); q_d.push_back(in_data1); end
      if (in_valid2 && in_addr2 != 5'd0) begin q_a.push_back(in_addr2); q_d.push_back(in_data2); end
    end
    $display("[%0t] %s v=%b%b a=%0d,%0d de=%b | rdy=%b WE=%b%b Aw=%0d,%0d WD=%h,%h hit=%b q=%0d",
             $time, tag, in_valid1, in_valid2, in_addr1, in_addr2, drain_en,
             in_ready, WE1, WE2, Aw1, Aw2, WD1, WD2, fwd_hit, q_a.size());
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic edge_();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string tag);
    mid();
    model_cycle(tag);
    edge_();
  endtask

  initial begin
    // Reset values while RSTn is held low.
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.WE1", 32'(WE1), 32'd0);
    chk("rst.WE2", 32'(WE2), 32'd0);
    chk("rst.Aw1", 32'(Aw1), 32'd0);
    chk("rst.WD2", WD2, 32'd0);
    chk("rst.fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst.fwd_data", fwd_data, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    edge_();

    // Two distinct registers drained together next cycle.
    set_in(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 5'd0);
    step("pair");
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd0);
    mid();
    chk("pair.WE1c", 32'(WE1), 32'd1);
    chk("pair.Aw1c", 32'(Aw1), 32'd3);
    chk("pair.WD1c", WD1, 32'h11);
    chk("pair.WE2c", 32'(WE2), 32'd1);
    chk("pair.Aw2c", 32'(Aw2), 32'd4);
    chk("pair.WD2c", WD2, 32'h22);
    model_cycle("pair_drain");
    edge_();
    step("pair_empty");

    // Same destination: only the younger value is written.
    set_in(1, 5'd5, 32'hA, 1, 5'd5, 32'hB, 1, 5'd0);
    step("same");
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd0);
    mid();
    chk("same.WE1c", 32'(WE1), 32'd0);
    chk("same.Aw2c", 32'(Aw2), 32'd5);
    chk("same.WD2c", WD2, 32'hB);
    model_cycle("same_drain");
    edge_();
    step("same_empty");

    // r0 result dropped, r7 enqueued alone.
    set_in(1, 5'd0, 32'h5, 1, 5'd7, 32'h9, 1, 5'd0);
    step("r0");
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd0);
    mid();
    chk("r0.WE1c", 32'(WE1), 32'd1);
    chk("r0.Aw1c", 32'(Aw1), 32'd7);
    chk("r0.WD1c", WD1, 32'h9);
    chk("r0.WE2c", 32'(WE2), 32'd0);
    model_cycle("r0_drain");
    edge_();

    // Fill to DEPTH, fifth pair refused, then drain two per cycle.
    for (int k = 0; k < 4; k++) begin
      set_in(1, 5'(2*k+1), 32'h100 + 32'(k), 1, 5'(2*k+2), 32'h200 + 32'(k), 0, 5'd0);
      step("fill");
    end
    set_in(1, 5'd20, 32'hDEAD, 1, 5'd21, 32'hBEEF, 0, 5'd0);
    mid();
    chk("full.in_ready", 32'(in_ready), 32'd0);
    model_cycle("full_push");
    edge_();
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd0);
    for (int k = 0; k < 4; k++) step("full_drain");
    mid();
    chk("full.empty_we1", 32'(WE1), 32'd0);
    model_cycle("full_empty");
    edge_();

    // Forwarding lookup over two queued r9 results.
    set_in(1, 5'd9, 32'h1, 0, 0, 0, 0, 5'd9);
    step("fwd1");
    set_in(1, 5'd9, 32'h2, 0, 0, 0, 0, 5'd9);
    step("fwd2");
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd9);
    mid();
`ifdef WB_FORWARD_EN
    chk("fwd.hit9", 32'(fwd_hit), 32'd1);
    chk("fwd.data9", fwd_data, 32'h2);
`else
    chk("fwd.hit9_off", 32'(fwd_hit), 32'd0);
`endif
    model_cycle("fwd9");
    edge_();
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd0);
    mid();
    chk("fwd.hit0", 32'(fwd_hit), 32'd0);
    model_cycle("fwd0");
    edge_();
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd0);
    step("fwd_drain");

    // Reset with five entries queued.
    set_in(1, 5'd11, 32'h51, 1, 5'd12, 32'h52, 0, 5'd0); step("pre_rst");
    set_in(1, 5'd13, 32'h53, 1, 5'd14, 32'h54, 0, 5'd0); step("pre_rst");
    set_in(1, 5'd15, 32'h55, 0, 0, 0, 0, 5'd15);          step("pre_rst");
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd15);
    RSTn = 1'b0;
    #1;
    chk("arst.WE1", 32'(WE1), 32'd0);
    chk("arst.WE2", 32'(WE2), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    chk("arst.WD1", WD1, 32'd0);
    chk("arst.fwd_hit", 32'(fwd_hit), 32'd0);
    q_a.delete();
    q_d.delete();
    edge_();
    @(negedge CLK);
    RSTn = 1'b1;
    edge_();
    for (int k = 0; k < 3; k++) step("post_rst");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      set_in($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
